// File: rtl/myo_spi_scheduler.sv
// Per-frame SPI transaction sequencer for the myocontrol muscle boards.
// Optional define MYO_SCHED_TIMEOUT_EN adds a spi_done watchdog and drives timeout_err.
module myo_spi_scheduler #(
  parameter int unsigned NUM_UNITS      = 6,
  parameter int unsigned PERIOD_CYCLES  = 100000,
  parameter int unsigned SETUP_CYCLES   = 4,
  parameter int unsigned GAP_CYCLES     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         run,
  input  logic [NUM_UNITS-1:0]         unit_mask,
  input  logic                         power_sense_n,
  input  logic                         spi_done,
  input  logic                         clear_overrun,
  output logic                         spi_start,
  output logic [NUM_UNITS-1:0]         ss_n_o,
  output logic [$clog2(NUM_UNITS)-1:0] cur_unit,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         overrun,
  output logic                         timeout_err
);

  localparam int unsigned IDX_W = $clog2(NUM_UNITS);
  localparam int unsigned CNT_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int unsigned MAX_D = (SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES;
  localparam int unsigned DLY_W = $clog2(MAX_D + 1);

  localparam logic [CNT_W-1:0]     CNT_LAST   = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [DLY_W-1:0]     SETUP_LAST = DLY_W'(SETUP_CYCLES - 1);
  localparam logic [DLY_W-1:0]     GAP_LAST   = DLY_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST   = IDX_W'(NUM_UNITS - 1);
  localparam logic [NUM_UNITS-1:0] ONE_HOT0   = {{(NUM_UNITS-1){1'b0}}, 1'b1};

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SCAN  = 3'd1;
  localparam logic [2:0] S_SETUP = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_BUSY  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DLY_W-1:0]     dly_q, dly_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     cur_q, cur_d;
  logic [NUM_UNITS-1:0] mask_q, mask_d;
  logic [NUM_UNITS-1:0] ss_q, ss_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;
  logic                 overrun_q, overrun_d;
  logic                 abort_q, abort_d;
  logic                 tick;
  logic                 power_ok;
  logic                 release_sel;

`ifdef MYO_SCHED_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             timeout_q, timeout_d;
`endif

  assign power_ok = ~power_sense_n;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (!run) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    dly_d        = dly_q;
    idx_d        = idx_q;
    cur_d        = cur_q;
    mask_d       = mask_q;
    ss_d         = ss_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    abort_d      = abort_q;
    release_sel  = 1'b0;
`ifdef MYO_SCHED_TIMEOUT_EN
    tmo_d        = tmo_q;
    timeout_d    = timeout_q;
`endif

    overrun_d = overrun_q;
    if (clear_overrun)   overrun_d = 1'b0;
    if (tick && busy_q)  overrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (tick && power_ok && (|unit_mask)) begin
          mask_d  = unit_mask;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (!power_ok) begin
          ss_d    = '1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (mask_q[idx_q]) begin
          cur_d   = idx_q;
          ss_d    = ~(ONE_HOT0 << idx_q);
          dly_d   = '0;
          state_d = S_SETUP;
        end else if (idx_q == IDX_LAST) begin
          frame_done_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = S_IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_SETUP: begin
        if (!power_ok) begin
          ss_d    = '1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (dly_q == SETUP_LAST) begin
          state_d = S_START;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      S_START: begin
        // power loss from here on only takes effect once the transaction ends
        abort_d = ~power_ok;
        state_d = S_BUSY;
`ifdef MYO_SCHED_TIMEOUT_EN
        tmo_d   = TMO_W'(1);
`endif
      end
      S_BUSY: begin
        if (!power_ok) abort_d = 1'b1;
        release_sel = spi_done;
`ifdef MYO_SCHED_TIMEOUT_EN
        if (!spi_done) begin
          if (tmo_q >= TMO_LAST) begin
            release_sel = 1'b1;
            timeout_d   = 1'b1;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
`endif
        if (release_sel) begin
          ss_d  = '1;
          dly_d = '0;
          if (abort_d) begin
            abort_d = 1'b0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (!power_ok) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (dly_q == GAP_LAST) begin
          if (idx_q == IDX_LAST) begin
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
            state_d      = S_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_SCAN;
          end
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      default: begin
        ss_d    = '1;
        busy_d  = 1'b0;
        abort_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      dly_q        <= '0;
      idx_q        <= '0;
      cur_q        <= '0;
      mask_q       <= '0;
      ss_q         <= '1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dly_q        <= dly_d;
      idx_q        <= idx_d;
      cur_q        <= cur_d;
      mask_q       <= mask_d;
      ss_q         <= ss_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      abort_q      <= abort_d;
    end
  end

`ifdef MYO_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign spi_start  = (state_q == S_START);
  assign ss_n_o     = ss_q;
  assign cur_unit   = cur_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_myo_spi_scheduler.sv
// Directed, table-driven bench for myo_spi_scheduler (PERIOD_CYCLES=1000, TIMEOUT_CYCLES=50).
module tb_myo_spi_scheduler;

  localparam int unsigned N = 6;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         run = 1'b0;
  logic [N-1:0] unit_mask = '0;
  logic         power_sense_n = 1'b1;
  logic         spi_done = 1'b0;
  logic         clear_overrun = 1'b0;
  logic         spi_start;
  logic [N-1:0] ss_n_o;
  logic [2:0]   cur_unit;
  logic         busy;
  logic         frame_done;
  logic         overrun;
  logic         timeout_err;

  int passed = 0;
  int total  = 0;
  int inv_viol = 0;

  myo_spi_scheduler #(
    .NUM_UNITS(6),
    .PERIOD_CYCLES(1000),
    .SETUP_CYCLES(4),
    .GAP_CYCLES(8),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .unit_mask(unit_mask),
    .power_sense_n(power_sense_n), .spi_done(spi_done), .clear_overrun(clear_overrun),
    .spi_start(spi_start), .ss_n_o(ss_n_o), .cur_unit(cur_unit), .busy(busy),
    .frame_done(frame_done), .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench watchdog expired");
  end

  // at most one select low, and spi_start only with exactly one select low
  always @(negedge clk) begin
    if (reset_n) begin
      if ($countones(~ss_n_o) > 1) inv_viol++;
      if (spi_start && $countones(~ss_n_o) != 1) inv_viol++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_busy(input int lim);
    for (int t = 0; t < lim && !busy; t++) @(negedge clk);
    check("frame_start", busy, 1);
  endtask

  task automatic wait_start(input int lim);
    for (int t = 0; t < lim && !spi_start; t++) @(negedge clk);
    check("spi_start_seen", spi_start, 1);
  endtask

  // answer each spi_start with spi_done two cycles later until the frame ends
  task automatic serve(input int lim, output logic fd);
    int da;
    da = -1;
    fd = 1'b0;
    for (int t = 0; t < lim && busy; t++) begin
      @(negedge clk);
      spi_done = (t == da);
      if (spi_start) da = t + 2;
      if (frame_done) fd = 1'b1;
    end
    spi_done = 1'b0;
  endtask

  task automatic do_frame(input logic [N-1:0] m, input int dly, input int exp_starts);
    int k, fall, done_at, nst;
    logic [N-1:0] exp_ss, prev;
    logic seen_fd;
    unit_mask = m;
    wait_busy(2500);
    unit_mask = ~m;
    k = 0; fall = -100; done_at = -1; nst = 0; seen_fd = 1'b0; prev = '1;
    for (int t = 0; t < 1000 && !seen_fd; t++) begin
      @(negedge clk);
      spi_done = (t == done_at);
      if (ss_n_o != '1 && prev == '1) begin
        while (k < N && !m[k]) k++;
        exp_ss = '1;
        if (k < N) exp_ss[k] = 1'b0;
        check("select", ss_n_o, exp_ss);
        check("cur_unit", cur_unit, k);
        k++;
        fall = t;
      end
      if (spi_start) begin
        nst++;
        check("setup_latency", t - fall, 4);
        done_at = t + dly;
      end
      if (frame_done) begin
        seen_fd = 1'b1;
        check("busy_at_frame_done", busy, 0);
      end
      prev = ss_n_o;
    end
    spi_done = 1'b0;
    check("frame_done", seen_fd, 1);
    check("start_count", nst, exp_starts);
    check("ss_after_frame", ss_n_o, 6'h3f);
  endtask

  typedef struct {
    logic [N-1:0] mask;
    int           dly;
    int           starts;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int   cnt_start, cnt_fd, cnt_busy, cnt_ss;
    logic fd;

    vecs[0] = '{mask: 6'b000101, dly: 10, starts: 2};
    vecs[1] = '{mask: 6'b000001, dly: 3,  starts: 1};
    vecs[2] = '{mask: 6'b100000, dly: 10, starts: 1};
    vecs[3] = '{mask: 6'b111111, dly: 1,  starts: 6};
    vecs[4] = '{mask: 6'b010010, dly: 20, starts: 2};

    repeat (3) @(negedge clk);
    check("rst_ss", ss_n_o, 6'h3f);
    check("rst_busy", busy, 0);
    check("rst_start", spi_start, 0);
    check("rst_fd", frame_done, 0);
    check("rst_ovr", overrun, 0);
    check("rst_tmo", timeout_err, 0);
    check("rst_cur", cur_unit, 0);
    reset_n = 1'b1;
    power_sense_n = 1'b0;
    run = 1'b1;

    for (int i = 0; i < 5; i++) do_frame(vecs[i].mask, vecs[i].dly, vecs[i].starts);

    // empty mask: ticks are dropped
    unit_mask = '0;
    cnt_start = 0; cnt_fd = 0; cnt_busy = 0; cnt_ss = 0;
    repeat (3000) begin
      @(negedge clk);
      if (spi_start) cnt_start++;
      if (frame_done) cnt_fd++;
      if (busy) cnt_busy++;
      if (ss_n_o != 6'h3f) cnt_ss++;
    end
    check("zero_mask_starts", cnt_start, 0);
    check("zero_mask_fd", cnt_fd, 0);
    check("zero_mask_busy", cnt_busy, 0);
    check("zero_mask_ss", cnt_ss, 0);

    // overrun: withhold spi_done past the next tick
    unit_mask = 6'b111111;
    wait_busy(1100);
    wait_start(50);
    repeat (1100) @(negedge clk);
    check("overrun_set", overrun, 1);
    check("busy_while_held", busy, 1);
    spi_done = 1'b1;
    @(negedge clk);
    spi_done = 1'b0;
    serve(1000, fd);
    check("overrun_frame_done", fd, 1);
    check("overrun_sticky", overrun, 1);
    clear_overrun = 1'b1;
    @(negedge clk);
    clear_overrun = 1'b0;
    check("overrun_cleared", overrun, 0);
    wait_busy(1100);
    serve(1000, fd);
    check("next_frame_done", fd, 1);
    check("overrun_stays_clear", overrun, 0);

    // power loss during SETUP of unit 2
    unit_mask = 6'b000100;
    wait_busy(1100);
    for (int t = 0; t < 20 && ss_n_o == 6'h3f; t++) @(negedge clk);
    check("pwr_sel", ss_n_o, 6'b111011);
    power_sense_n = 1'b1;
    @(negedge clk);
    check("pwr_ss_release", ss_n_o, 6'h3f);
    check("pwr_busy", busy, 0);
    check("pwr_no_fd", frame_done, 0);
    cnt_start = 0; cnt_fd = 0;
    repeat (20) begin
      @(negedge clk);
      if (spi_start) cnt_start++;
      if (frame_done) cnt_fd++;
    end
    check("pwr_no_start", cnt_start, 0);
    check("pwr_no_fd_later", cnt_fd, 0);
    power_sense_n = 1'b0;

    unit_mask = 6'b000011;
    wait_busy(1100);
`ifdef MYO_SCHED_TIMEOUT_EN
    wait_start(50);
    for (int t = 1; t <= 50; t++) begin
      @(negedge clk);
      if (t == 49) check("tmo_before", timeout_err, 0);
      if (t == 50) begin
        check("tmo_set", timeout_err, 1);
        check("tmo_release", ss_n_o, 6'h3f);
      end
    end
    wait_start(40);
    check("tmo_next_sel", ss_n_o, 6'b111101);
    check("tmo_next_cur", cur_unit, 1);
    serve(1000, fd);
    check("tmo_frame_done", fd, 1);
    check("tmo_sticky", timeout_err, 1);
`else
    serve(1000, fd);
    check("no_tmo_frame_done", fd, 1);
    check("tmo_tied_low", timeout_err, 0);
`endif

    // asynchronous reset during BUSY
    unit_mask = 6'b000001;
    wait_busy(1100);
    wait_start(50);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_ss", ss_n_o, 6'h3f);
    check("arst_busy", busy, 0);
    check("arst_start", spi_start, 0);
    @(negedge clk);
    reset_n = 1'b1;
    unit_mask = 6'b000011;
    wait_busy(1100);
    for (int t = 0; t < 20 && ss_n_o == 6'h3f; t++) @(negedge clk);
    check("arst_restart_sel", ss_n_o, 6'b111110);
    serve(1000, fd);
    check("arst_frame_done", fd, 1);

    check("select_invariant", inv_viol, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/myo_spi_scheduler.md
Name: myo_spi_scheduler

Overview:
- Sequences SPI transactions to up to NUM_UNITS muscle-control boards on a shared SPI bus, which carries one sck/mosi/miso and one active-low slave select per board.
- Sits between the myocontrol register block and the SPI word-shift engine.
- Once per control period, it walks the enabled units in ascending index order. For each unit it asserts that unit's slave select, starts the shift engine, waits for completion, then releases the select.
- It gates all activity on motor power-sense and reports frame completion and overrun.

Parameters:
- NUM_UNITS, 6: number of muscle boards, which is also the slave-select width.
- PERIOD_CYCLES, 100000: clk cycles per control frame (tick period).
- SETUP_CYCLES, 4: cycles from select assertion to spi_start.
- GAP_CYCLES, 8: cycles with all selects high between consecutive units.
- TIMEOUT_CYCLES, 1024: wait limit for spi_done. Used only with MYO_SCHED_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- run  in  1  scheduling enable
- unit_mask  in  NUM_UNITS  per-unit enable, bit i = unit i
- power_sense_n  in  1  low = motor power present
- spi_done  in  1  one-cycle pulse from the shift engine when a transaction ends
- clear_overrun  in  1  clears the overrun flag
- spi_start  out  1  one-cycle pulse that launches a transaction
- ss_n_o  out  NUM_UNITS  active-low slave selects, at most one bit low at a time
- cur_unit  out  $clog2(NUM_UNITS)  index of the unit being serviced
- busy  out  1  high from frame start until the frame ends
- frame_done  out  1  one-cycle pulse when a frame completes
- overrun  out  1  sticky: a tick arrived while a frame was active
- timeout_err  out  1  sticky: spi_done was not returned in time

Behaviour:
- Reset (async assert, sync release): state IDLE, ss_n_o all ones, all other outputs 0, all counters 0.
- Tick counter:
  - Counts 0..PERIOD_CYCLES-1 while run=1 and holds at 0 while run=0.
  - A tick is a one-cycle internal pulse raised when the count wraps.
- IDLE:
  - Condition to start a frame: tick && power_sense_n==0 && unit_mask!=0.
  - On that condition: latch unit_mask into mask_q, idx<=0, busy<=1, go to SCAN.
  - A tick that fails the condition is dropped silently.
- SCAN: examines one index per cycle.
  - If mask_q[idx]=1: cur_unit<=idx, go to SETUP, and drive ss_n_o[idx] low from the next cycle.
  - Else if idx==NUM_UNITS-1: frame_done pulse, busy<=0, go to IDLE.
  - Else: idx<=idx+1.
- SETUP: hold the select low for SETUP_CYCLES cycles, then go to START.
- START: spi_start=1 for exactly one cycle, then go to BUSY.
- BUSY:
  - Wait for spi_done. On spi_done, ss_n_o returns to all ones on the next cycle and the state goes to GAP.
  - spi_done in any state other than BUSY is ignored.
- GAP:
  - Hold all selects high for GAP_CYCLES cycles.
  - Then, if idx==NUM_UNITS-1: frame_done pulse and go to IDLE. Otherwise idx<=idx+1 and go to SCAN.
- Latency: with unit 0 enabled, a tick in cycle T gives SCAN at T+1, ss_n_o[0] low at T+2, and spi_start at T+2+SETUP_CYCLES.
- Overrun:
  - A tick while busy=1 sets overrun, and the tick is dropped.
  - clear_overrun clears overrun. If clear_overrun and a set event occur in the same cycle, set wins.
- Power loss (power_sense_n=1):
  - In SCAN/SETUP/GAP: go to IDLE the next cycle, with all selects high, busy<=0 and no frame_done.
  - In START/BUSY: finish the current transaction and wait for spi_done, then go to IDLE with no frame_done.
- run deasserted mid-frame: the current frame completes normally. No new frame starts.
- unit_mask changes mid-frame take effect at the next frame only.
- Invariants: ss_n_o is never low on more than one bit. spi_start is only ever issued while exactly one select is low.

Optional Feature:
- MYO_SCHED_TIMEOUT_EN defined:
  - In BUSY, a counter runs from spi_start.
  - If it reaches TIMEOUT_CYCLES without spi_done: set timeout_err (sticky), release the select, go to GAP, and continue with the next unit.
  - timeout_err is cleared only by reset.
- MYO_SCHED_TIMEOUT_EN undefined: BUSY waits indefinitely, and timeout_err is tied to 0.

Test Plan:
Bench settings: NUM_UNITS=6, PERIOD_CYCLES=1000, SETUP_CYCLES=4, GAP_CYCLES=8.
1. mask=6'b000101, power ok, spi_done returned 10 cycles after each spi_start -> ss_n_o goes 6'b111110 then 6'b111011; exactly 2 spi_start pulses, each 4 cycles after its select falls; one frame_done; busy low afterwards.
2. mask=6'b000000, run=1 for 3000 cycles -> no spi_start, no frame_done, ss_n_o stays 6'b111111.
3. mask=6'b111111, spi_done withheld past a tick -> overrun=1; then clear_overrun pulse -> overrun=0; frames continue at the following ticks.
4. mask=6'b000100, power_sense_n raised during SETUP of unit 2 -> ss_n_o=6'b111111 next cycle; no spi_start; no frame_done; busy=0.
5. MYO_SCHED_TIMEOUT_EN defined, TIMEOUT_CYCLES=50, mask=6'b000011, spi_done never returned for unit 0 -> timeout_err=1 at 50 cycles after spi_start; after GAP, unit 1 is selected and started.
6. reset_n pulsed low during BUSY -> ss_n_o=6'b111111 and busy=0 immediately, no clk edge required; after release, the next frame starts from unit 0.
